divider: RTL

Iterative 32-bit integer divider: the inverse companion of the ALU multiplier, sharing its start/busy/valid handshake and operand naming. It produces quotient and remainder with RISC-V DIV/DIVU/REM/REMU semantics, retiring two quotient bits per cycle. It sits in the ALU beside the multiplier and is driven by the same issue logic.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 23 ++
 rtl/divider.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative divider.
package div_pkg;
  localparam int XLEN      = 32;
  localparam int DIV_ITERS = 16;

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] OVF_QUOT  = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } div_state_e;
endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
(
  input  logic [XLEN:0]   rem_in,
  input  logic            dvd_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic            q_bit
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  always_comb begin
    shifted = {rem_in[XLEN-1:0], dvd_bit};
    diff    = {1'b0, shifted} - {2'b00, divisor};
    // a set top bit before the shift already guarantees the subtraction succeeds
    q_bit   = rem_in[XLEN] | ~diff[XLEN+1];
    rem_out = q_bit ? diff[XLEN:0] : shifted;
  end

endmodule

// File: rtl/divider.sv
// Iterative 32-bit divider (RISC-V DIV/DIVU/REM/REMU), two quotient bits per cycle.
// Optional DIVIDER_EARLY_OUT_EN skips iteration for divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | waiting for start, operands latched on accept
// CALC  | 16 cycles of two chained restoring steps
// FIX   | apply signs / special cases, write result, pulse valid
module divider
  import div_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  input  logic              op_signed,
  input  logic              start,
  output logic [2*XLEN-1:0] result,
  output logic              valid,
  output logic              busy
);

  div_state_e state_q, state_d;

  logic [XLEN-1:0] dvd_q, dsr_q, quot_q, rs1_q;
  logic [XLEN:0]   rem_q, rem_mid, rem_nxt;
  logic [3:0]      cnt_q;
  logic            q_neg_q, r_neg_q, div0_q, ovf_q;
  logic            qb_hi, qb_lo;

  logic            sign1, sign2, is_div0, is_ovf, last_iter;
  logic [XLEN-1:0] mag1, mag2, q_fix, r_fix;

  always_comb begin
    sign1     = op_signed & rs1[XLEN-1];
    sign2     = op_signed & rs2[XLEN-1];
    mag1      = sign1 ? -rs1 : rs1;
    mag2      = sign2 ? -rs2 : rs2;
    is_div0   = (rs2 == '0);
    is_ovf    = op_signed && (rs1 == OVF_QUOT) && (rs2 == '1);
    last_iter = (cnt_q == 4'(DIV_ITERS - 1));
  end

  div_step u_step_hi (
    .rem_in (rem_q),
    .dvd_bit(dvd_q[XLEN-1]),
    .divisor(dsr_q),
    .rem_out(rem_mid),
    .q_bit  (qb_hi)
  );

  div_step u_step_lo (
    .rem_in (rem_mid),
    .dvd_bit(dvd_q[XLEN-2]),
    .divisor(dsr_q),
    .rem_out(rem_nxt),
    .q_bit  (qb_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef DIVIDER_EARLY_OUT_EN
          state_d = (is_div0 || is_ovf) ? FIX : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC:    if (last_iter) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q_fix = q_neg_q ? -quot_q : quot_q;
    r_fix = r_neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    if (div0_q) begin
      q_fix = DIV0_QUOT;
      r_fix = rs1_q;
    end else if (ovf_q) begin
      q_fix = OVF_QUOT;
      r_fix = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result  <= '0;
      valid   <= 1'b0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quot_q  <= '0;
      rs1_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q   <= mag1;
            dsr_q   <= mag2;
            rs1_q   <= rs1;
            q_neg_q <= sign1 ^ sign2;
            r_neg_q <= sign1;
            div0_q  <= is_div0;
            ovf_q   <= is_ovf;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
          end
        end
        CALC: begin
          rem_q  <= rem_nxt;
          quot_q <= {quot_q[XLEN-3:0], qb_hi, qb_lo};
          dvd_q  <= {dvd_q[XLEN-3:0], 2'b00};
          cnt_q  <= cnt_q + 4'd1;
        end
        FIX: begin
          result <= {r_fix, q_fix};
          valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

endmodule
